// File: rtl/cmd_framer_if.sv
// Byte-in / frame-out signal bundle for cmd_framer.
// master is the framer side, slave is the byte source and frame consumer.
interface cmd_framer_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  cmd;
   logic [31:0] arg;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        busy;
   logic        err_opcode;
   logic        err_overrun;
   logic        err_timeout;

   modport master (
      input  rx_data, rx_valid, cmd_ready,
      output cmd, arg, cmd_valid, busy, err_opcode, err_overrun, err_timeout
   );

   modport slave (
      output rx_data, rx_valid, cmd_ready,
      input  cmd, arg, cmd_valid, busy, err_opcode, err_overrun, err_timeout
   );
endinterface

// File: rtl/cmd_framer.sv
// Assembles 5-byte UART commands (opcode + 32-bit MSB-first operand) into a held output frame.
// Define CMD_FRAMER_TIMEOUT_EN to build the inter-byte timeout; otherwise partial frames wait forever.
module cmd_framer #(
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter logic [7:0]  MAX_OPCODE     = 8'h07
) (
   input  logic         clk,
   input  logic         reset,
   cmd_framer_if.master bus
);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   function automatic logic opcode_legal(input logic [7:0] op);
      opcode_legal = (op != 8'h00) && (op <= MAX_OPCODE);
   endfunction

   state_t      state_r, state_nx_s;
   logic [2:0]  byte_cnt_r, byte_cnt_nx_s;
   logic [7:0]  opcode_r, opcode_nx_s;
   logic [23:0] arg_sh_r, arg_sh_nx_s;
   logic [7:0]  cmd_r, cmd_nx_s;
   logic [31:0] arg_r, arg_nx_s;
   logic        cmd_valid_r, cmd_valid_nx_s;
   logic        busy_r, busy_nx_s;
   logic        err_opcode_r, err_opcode_nx_s;
   logic        err_overrun_r, err_overrun_nx_s;
   logic        err_timeout_r, err_timeout_nx_s;
   logic        timeout_s;
   logic        out_free_s;

   // A held frame leaving this cycle frees the slot for a back-to-back load.
   assign out_free_s = ~cmd_valid_r | bus.cmd_ready;

`ifdef CMD_FRAMER_TIMEOUT_EN
   localparam int unsigned     TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};
   localparam logic [TMO_W-1:0] TMO_ZERO  = {TMO_W{1'b0}};
   localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

   logic [TMO_W-1:0] idle_cnt_r, idle_cnt_nx_s;

   // Idle counter: cleared by every byte, counts while collecting, saturates.
   always_comb begin
      timeout_s     = 1'b0;
      idle_cnt_nx_s = idle_cnt_r;
      if ((state_r == ST_COLLECT) && (idle_cnt_r >= TMO_LIMIT)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
      if (bus.rx_valid) begin
         idle_cnt_nx_s = TMO_ZERO;
      end else if (timeout_s) begin
         idle_cnt_nx_s = TMO_ZERO;
      end else if ((state_r == ST_COLLECT) && (idle_cnt_r != TMO_MAX)) begin
         idle_cnt_nx_s = idle_cnt_r + TMO_ONE;
      end else begin
         idle_cnt_nx_s = idle_cnt_r;
      end
   end

   // Idle counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_r <= TMO_ZERO;
      end else begin
         idle_cnt_r <= idle_cnt_nx_s;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state, frame assembly and frame evaluation.
   always_comb begin
      state_nx_s       = state_r;
      byte_cnt_nx_s    = byte_cnt_r;
      opcode_nx_s      = opcode_r;
      arg_sh_nx_s      = arg_sh_r;
      cmd_nx_s         = cmd_r;
      arg_nx_s         = arg_r;
      err_opcode_nx_s  = 1'b0;
      err_overrun_nx_s = 1'b0;
      err_timeout_nx_s = timeout_s;
      if (cmd_valid_r && bus.cmd_ready) begin
         cmd_valid_nx_s = 1'b0;
      end else begin
         cmd_valid_nx_s = cmd_valid_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (bus.rx_valid) begin
               state_nx_s    = ST_COLLECT;
               byte_cnt_nx_s = 3'd1;
               opcode_nx_s   = bus.rx_data;
            end else begin
               state_nx_s    = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (timeout_s && bus.rx_valid) begin
               // The coinciding byte starts a fresh frame.
               state_nx_s    = ST_COLLECT;
               byte_cnt_nx_s = 3'd1;
               opcode_nx_s   = bus.rx_data;
            end else if (timeout_s) begin
               state_nx_s    = ST_IDLE;
               byte_cnt_nx_s = 3'd0;
            end else if (bus.rx_valid) begin
               if (byte_cnt_r == 3'd4) begin
                  state_nx_s    = ST_IDLE;
                  byte_cnt_nx_s = 3'd0;
                  if (!opcode_legal(opcode_r)) begin
                     err_opcode_nx_s = 1'b1;
                  end else if (out_free_s) begin
                     cmd_nx_s       = opcode_r;
                     arg_nx_s       = {arg_sh_r, bus.rx_data};
                     cmd_valid_nx_s = 1'b1;
                  end else begin
                     err_overrun_nx_s = 1'b1;
                  end
               end else begin
                  byte_cnt_nx_s = byte_cnt_r + 3'd1;
                  arg_sh_nx_s   = {arg_sh_r[15:0], bus.rx_data};
               end
            end else begin
               state_nx_s = ST_COLLECT;
            end
         end
         default: begin
            state_nx_s    = ST_IDLE;
            byte_cnt_nx_s = 3'd0;
         end
      endcase

      busy_nx_s = (state_nx_s == ST_COLLECT);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         byte_cnt_r    <= 3'd0;
         opcode_r      <= 8'h00;
         arg_sh_r      <= 24'h000000;
         cmd_r         <= 8'h00;
         arg_r         <= 32'h0000_0000;
         cmd_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
         err_opcode_r  <= 1'b0;
         err_overrun_r <= 1'b0;
         err_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         byte_cnt_r    <= byte_cnt_nx_s;
         opcode_r      <= opcode_nx_s;
         arg_sh_r      <= arg_sh_nx_s;
         cmd_r         <= cmd_nx_s;
         arg_r         <= arg_nx_s;
         cmd_valid_r   <= cmd_valid_nx_s;
         busy_r        <= busy_nx_s;
         err_opcode_r  <= err_opcode_nx_s;
         err_overrun_r <= err_overrun_nx_s;
         err_timeout_r <= err_timeout_nx_s;
      end
   end

   assign bus.cmd         = cmd_r;
   assign bus.arg         = arg_r;
   assign bus.cmd_valid   = cmd_valid_r;
   assign bus.busy        = busy_r;
   assign bus.err_opcode  = err_opcode_r;
   assign bus.err_overrun = err_overrun_r;
   assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_cmd_framer.sv
// Directed bench for cmd_framer; expected values are hand-computed from the frame format.
module tb_cmd_framer;
   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   n_opc;
   int   n_ovr;
   int   n_tmo;
   int   base;

   cmd_framer_if bus ();

   cmd_framer #(
      .TIMEOUT_CYCLES(100),
      .MAX_OPCODE    (8'h07)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Error pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      n_opc = n_opc + int'(bus.err_opcode);
      n_ovr = n_ovr + int'(bus.err_overrun);
      n_tmo = n_tmo + int'(bus.err_timeout);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
      send(b0);
      send(b1);
      send(b2);
      send(b3);
      send(b4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; n_opc = 0; n_ovr = 0; n_tmo = 0;
      reset = 1'b1;
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.cmd_ready = 1'b0;
      repeat (3) tick();
      check("rst_cmd", {24'h0, bus.cmd}, 32'h0);
      check("rst_arg", bus.arg, 32'h0);
      check("rst_flags", {26'h0, bus.cmd_valid, bus.busy, bus.err_opcode, bus.err_overrun,
                          bus.err_timeout, 1'b0}, 32'h0);
      reset = 1'b0;
      tick();

      // Single frame, consumer always ready.
      bus.cmd_ready = 1'b1;
      send(8'h01);
      check("busy_collect", {31'h0, bus.busy}, 32'h1);
      send(8'h00); send(8'h00); send(8'h00); send(8'h01);
      check("f1_valid", {31'h0, bus.cmd_valid}, 32'h1);
      check("f1_cmd", {24'h0, bus.cmd}, 32'h01);
      check("f1_arg", bus.arg, 32'h0000_0001);
      check("f1_busy", {31'h0, bus.busy}, 32'h0);
      tick();
      check("f1_one_clk", {31'h0, bus.cmd_valid}, 32'h0);

      // Overrun while the held frame is not accepted.
      bus.cmd_ready = 1'b0;
      send5(8'h02, 8'h00, 8'h00, 8'h00, 8'h01);
      check("f2_cmd", {24'h0, bus.cmd}, 32'h02);
      base = n_ovr;
      send5(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
      check("ovr_pulse", {31'h0, bus.err_overrun}, 32'h1);
      tick();
      check("ovr_once", n_ovr - base, 32'd1);
      check("ovr_held_cmd", {24'h0, bus.cmd}, 32'h02);
      check("ovr_held_arg", bus.arg, 32'h0000_0001);
      bus.cmd_ready = 1'b1;
      tick();
      check("f2_accepted", {31'h0, bus.cmd_valid}, 32'h0);
      bus.cmd_ready = 1'b0;

      // Illegal opcode above the limit.
      send5(8'h09, 8'h12, 8'h34, 8'h56, 8'h78);
      check("opc_pulse", {31'h0, bus.err_opcode}, 32'h1);
      check("opc_valid", {31'h0, bus.cmd_valid}, 32'h0);
      check("opc_cmd", {24'h0, bus.cmd}, 32'h02);
      check("opc_arg", bus.arg, 32'h0000_0001);

      // Opcode 0 while output occupied: only the opcode error.
      send5(8'h03, 8'h00, 8'h00, 8'h00, 8'h02);
      check("f3_arg", bus.arg, 32'h0000_0002);
      base = n_ovr;
      send5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      check("both_opc", {31'h0, bus.err_opcode}, 32'h1);
      check("both_no_ovr", n_ovr - base, 32'd0);
      check("both_cmd", {24'h0, bus.cmd}, 32'h03);
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;

      // Inter-byte gap after a partial frame.
      base = n_tmo;
      send(8'h04);
      send(8'hAA);
      repeat (150) tick();
`ifdef CMD_FRAMER_TIMEOUT_EN
      check("tmo_once", n_tmo - base, 32'd1);
      check("tmo_idle", {31'h0, bus.busy}, 32'h0);
      send5(8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
      check("tmo_cmd", {24'h0, bus.cmd}, 32'h05);
      check("tmo_arg", bus.arg, 32'h0000_0000);
`else
      check("notmo_none", n_tmo - base, 32'd0);
      check("notmo_busy", {31'h0, bus.busy}, 32'h1);
      send(8'h05); send(8'h00); send(8'h00);
      check("notmo_cmd", {24'h0, bus.cmd}, 32'h04);
      check("notmo_arg", bus.arg, 32'hAA05_0000);
`endif
      check("gap_valid", {31'h0, bus.cmd_valid}, 32'h1);

      // Reset mid-frame with a held frame; the byte in the reset cycle is ignored.
      base = n_opc + n_ovr + n_tmo;
      send(8'h01); send(8'h11); send(8'h22);
      reset = 1'b1;
      bus.rx_data = 8'h33; bus.rx_valid = 1'b1;
      tick();
      reset = 1'b0;
      bus.rx_valid = 1'b0;
      check("mrst_valid", {31'h0, bus.cmd_valid}, 32'h0);
      check("mrst_busy", {31'h0, bus.busy}, 32'h0);
      check("mrst_cmd", {24'h0, bus.cmd}, 32'h00);
      send5(8'h06, 8'h00, 8'h00, 8'h00, 8'h07);
      check("mrst_f_cmd", {24'h0, bus.cmd}, 32'h06);
      check("mrst_f_arg", bus.arg, 32'h0000_0007);
      tick();
      check("mrst_no_err", (n_opc + n_ovr + n_tmo) - base, 32'd0);

      // Back-to-back: old frame accepted in the same cycle the new one completes.
      base = n_ovr;
      send(8'h07); send(8'h00); send(8'h00); send(8'h00);
      bus.rx_data = 8'h01; bus.rx_valid = 1'b1; bus.cmd_ready = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      check("b2b_valid", {31'h0, bus.cmd_valid}, 32'h1);
      check("b2b_cmd", {24'h0, bus.cmd}, 32'h07);
      check("b2b_arg", bus.arg, 32'h0000_0001);
      tick();
      check("b2b_drain", {31'h0, bus.cmd_valid}, 32'h0);
      check("b2b_no_ovr", n_ovr - base, 32'd0);
      bus.cmd_ready = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmd_framer.md
CMD_FRAMER -- requirements
Module: cmd_framer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000: maximum idle clocks allowed between bytes of one frame.
REQ-002 Parameter MAX_OPCODE, default 8'h07: highest legal opcode; legal range is 8'h01..MAX_OPCODE.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 cmd  output  8  opcode of the delivered frame.
REQ-008 arg  output  32  operand of the delivered frame.
REQ-009 cmd_valid  output  1  cmd/arg hold a frame not yet accepted.
REQ-010 cmd_ready  input  1  downstream accepts the frame when high together with cmd_valid.
REQ-011 busy  output  1  high while a partial frame is being collected (byte count 1..4).
REQ-012 err_opcode  output  1  one-cycle pulse: a complete frame had an illegal opcode.
REQ-013 err_overrun  output  1  one-cycle pulse: a complete frame was dropped because the output was still occupied.
REQ-014 err_timeout  output  1  one-cycle pulse: a partial frame was discarded after an inter-byte timeout.

Function
REQ-015 The frame is 5 bytes: byte 0 is the opcode, and bytes 1..4 are arg[31:24], arg[23:16], arg[15:8] and arg[7:0], MSB first.
REQ-016 State machine: IDLE (count 0) -> COLLECT on any rx_valid; COLLECT increments the count per rx_valid; the 5th byte returns to IDLE and evaluates the frame.
REQ-017 Evaluation occurs in the cycle of the 5th rx_valid, and results appear on the next clock.
REQ-018 Evaluation with a legal opcode and the output register free loads cmd/arg and sets cmd_valid; latency is 1 clock from the 5th rx_valid.
REQ-019 The output register counts as free when cmd_valid=0, or when cmd_valid=1 and cmd_ready=1 in the same cycle; in the second case the old frame is accepted and the new frame is loaded back-to-back, with no bubble.
REQ-020 Evaluation with an opcode of 0 or greater than MAX_OPCODE drops the frame, pulses err_opcode, and leaves cmd/arg/cmd_valid unchanged.
REQ-021 Evaluation with a legal opcode while the output is not free drops the new frame, pulses err_overrun, and keeps the held frame intact.
REQ-022 If both REQ-020 and REQ-021 apply to the same frame, only err_opcode pulses.
REQ-023 cmd_valid clears on the clock after cmd_valid and cmd_ready are both high, unless REQ-019 reloads it.
REQ-024 cmd and arg are stable while cmd_valid=1 and cmd_ready=0.
REQ-025 The idle counter clears on every rx_valid and increments each clock while in COLLECT; it saturates, never wraps.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES in COLLECT, the partial frame is discarded, the state returns to IDLE, and err_timeout pulses once.
REQ-027 If rx_valid coincides with the timeout cycle, the byte is taken as byte 0 of a new frame and err_timeout still pulses.
REQ-028 cmd_ready has no effect while cmd_valid=0.
REQ-029 busy=1 exactly when the state is COLLECT.

Reset
REQ-030 While reset=1 at a clock edge: state IDLE, byte count 0, idle counter 0, cmd=8'h00, arg=32'h0, and cmd_valid, busy and all err_* outputs 0.
REQ-031 Reset asserted mid-frame or with cmd_valid=1 discards all pending data; no error pulse is generated.
REQ-032 rx_valid bytes sampled in a reset cycle are ignored.

Configuration
REQ-033 Macro CMD_FRAMER_TIMEOUT_EN defined: the timeout logic of REQ-025..REQ-027 is present.
REQ-034 CMD_FRAMER_TIMEOUT_EN undefined: no idle counter is built, a partial frame waits indefinitely, err_timeout is tied to 0, and TIMEOUT_CYCLES is ignored.

Verification
REQ-035 Send bytes 01 00 00 00 01 with cmd_ready=1 -> cmd=8'h01, arg=32'h00000001, and cmd_valid high for exactly 1 clock, 1 clock after the 5th strobe.
REQ-036 With cmd_ready=0, send 02 00 00 00 01 and then 03 00 00 00 00 -> the first frame is held with cmd=02, err_overrun pulses once, and after raising cmd_ready the 02 frame is accepted and cmd_valid drops.
REQ-037 Send 09 12 34 56 78 -> err_opcode pulses, cmd_valid stays 0, and cmd/arg are unchanged.
REQ-038 With the macro defined and TIMEOUT_CYCLES=100, send 04 AA, wait 150 clocks, then send 05 00 00 00 00 -> err_timeout pulses once and cmd=05, arg=0 is delivered.
REQ-039 Assert reset for 1 clock after 3 bytes of 01 xx xx, then send 06 00 00 00 07 -> no error pulses occur and cmd=06, arg=32'h7 is delivered.
REQ-040 Complete frame 07 00 00 00 01 while cmd_valid=1 and cmd_ready=1 in the same cycle -> the old frame is accepted, the next clock shows cmd=07 with cmd_valid=1, and err_overrun does not pulse.
